// File: rtl/score_pkg.sv
// Shared glyph geometry, address/coordinate types and the glyph-address
// validity check used by the score digit renderer.
package score_pkg;

    localparam int GLYPH_W        = 8;
    localparam int GLYPH_H        = 16;
    localparam int GLYPH_STRIDE   = 16;
    localparam int MAX_GLYPH_ADDR = 144;

    typedef logic [7:0] glyph_addr_t;
    typedef logic [9:0] pix_coord_t;

    // A usable base sits on a glyph boundary and inside the ten-glyph ROM.
    function automatic logic glyph_addr_ok(input glyph_addr_t a);
        return ((int'(a) % GLYPH_STRIDE) == 0) && (int'(a) <= MAX_GLYPH_ADDR);
    endfunction

endpackage

// File: rtl/score_digit_renderer_hit.sv
// Combinational test of whether a scan position lies inside one digit box,
// returning the glyph row and column it maps to after magnification.
module digit_region_hit
    import score_pkg::*;
#(
    parameter int REGION_X   = 560,
    parameter int REGION_Y   = 16,
    parameter int SCALE_LOG2 = 1
) (
    input  pix_coord_t  draw_x,
    input  pix_coord_t  draw_y,
    output logic        in_region,
    output logic [3:0]  row,
    output logic [2:0]  col
);

    localparam int W = GLYPH_W << SCALE_LOG2;
    localparam int H = GLYPH_H << SCALE_LOG2;

    localparam pix_coord_t X_LO = pix_coord_t'(REGION_X);
    localparam pix_coord_t X_HI = pix_coord_t'(REGION_X + W);
    localparam pix_coord_t Y_LO = pix_coord_t'(REGION_Y);
    localparam pix_coord_t Y_HI = pix_coord_t'(REGION_Y + H);

    // Offsets are only formed once the box test passes, so they never wrap.
    always_comb begin
        in_region = (draw_x >= X_LO) && (draw_x < X_HI) &&
                    (draw_y >= Y_LO) && (draw_y < Y_HI);
        row = '0;
        col = '0;
        if (in_region) begin
            row = 4'((draw_y - Y_LO) >> SCALE_LOG2);
            col = 3'((draw_x - X_LO) >> SCALE_LOG2);
        end
    end

endmodule

// File: rtl/score_digit_renderer.sv
// Two-digit score overlay: per-frame shadow of the glyph bases, ROM address
// generation and a three-stage pixel pipeline covering the ROM read latency.
module score_digit_renderer
    import score_pkg::*;
#(
    parameter int SCORE_X            = 560,
    parameter int SCORE_Y            = 16,
    parameter int SCALE_LOG2         = 1,
    parameter int DIGIT_GAP          = 4,
    parameter int BLANK_LEADING_ZERO = 1
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        vs,
    input  glyph_addr_t numAddr1,
    input  glyph_addr_t numAddr2,
    input  pix_coord_t  DrawX,
    input  pix_coord_t  DrawY,
    output glyph_addr_t rom_addr,
    input  logic [7:0]  rom_data,
    output logic        score_pixel_on
);

    localparam int W = GLYPH_W << SCALE_LOG2;

    logic        tens_in, ones_in;
    logic [3:0]  tens_row, ones_row;
    logic [2:0]  tens_col, ones_col;

    digit_region_hit #(
        .REGION_X  (SCORE_X),
        .REGION_Y  (SCORE_Y),
        .SCALE_LOG2(SCALE_LOG2)
    ) u_tens (
        .draw_x   (DrawX),
        .draw_y   (DrawY),
        .in_region(tens_in),
        .row      (tens_row),
        .col      (tens_col)
    );

    digit_region_hit #(
        .REGION_X  (SCORE_X + W + DIGIT_GAP),
        .REGION_Y  (SCORE_Y),
        .SCALE_LOG2(SCALE_LOG2)
    ) u_ones (
        .draw_x   (DrawX),
        .draw_y   (DrawY),
        .in_region(ones_in),
        .row      (ones_row),
        .col      (ones_col)
    );

    logic        vs_dly_q,   vs_dly_d;
    glyph_addr_t shadow1_q,  shadow1_d;
    glyph_addr_t shadow2_q,  shadow2_d;
    glyph_addr_t rom_addr_q, rom_addr_d;
    logic        hit1_q,     hit1_d;
    logic [2:0]  col1_q,     col1_d;
    logic        hit2_q,     hit2_d;
    logic [2:0]  col2_q,     col2_d;
    logic        pixel_q,    pixel_d;
    logic        frame_start;
    logic        tens_ok, ones_ok;

    always_comb begin
        vs_dly_d    = vs;
        frame_start = vs_dly_q & ~vs;
        shadow1_d   = frame_start ? numAddr1 : shadow1_q;
        shadow2_d   = frame_start ? numAddr2 : shadow2_q;

        tens_ok = glyph_addr_ok(shadow1_q) &&
                  !((BLANK_LEADING_ZERO != 0) && (shadow1_q == '0));
        ones_ok = glyph_addr_ok(shadow2_q);

        // Stage 1 reads the current shadow, so a same-edge capture only
        // takes effect from the following pixel.
        rom_addr_d = '0;
        hit1_d     = 1'b0;
        col1_d     = '0;
        if (tens_in) begin
            rom_addr_d = shadow1_q + glyph_addr_t'(tens_row);
            hit1_d     = tens_ok;
            col1_d     = tens_col;
        end else if (ones_in) begin
            rom_addr_d = shadow2_q + glyph_addr_t'(ones_row);
            hit1_d     = ones_ok;
            col1_d     = ones_col;
        end

        hit2_d  = hit1_q;
        col2_d  = col1_q;
        pixel_d = hit2_q & rom_data[3'd7 - col2_q];
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            vs_dly_q   <= 1'b1;
            shadow1_q  <= '0;
            shadow2_q  <= '0;
            rom_addr_q <= '0;
            hit1_q     <= 1'b0;
            col1_q     <= '0;
            hit2_q     <= 1'b0;
            col2_q     <= '0;
            pixel_q    <= 1'b0;
        end else begin
            vs_dly_q   <= vs_dly_d;
            shadow1_q  <= shadow1_d;
            shadow2_q  <= shadow2_d;
            rom_addr_q <= rom_addr_d;
            hit1_q     <= hit1_d;
            col1_q     <= col1_d;
            hit2_q     <= hit2_d;
            col2_q     <= col2_d;
            pixel_q    <= pixel_d;
        end
    end

    assign rom_addr       = rom_addr_q;
    assign score_pixel_on = pixel_q;

endmodule
